// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DefWidth  = 32;
  localparam int unsigned DefNregs  = 16;
  localparam int unsigned DefNread  = 3;
  localparam bit          DefBypass = 1'b1;

  // Index of the write port that wins when both ports target the same register.
  localparam int unsigned PortPrio = 1;

  // The highest architectural index is the PC; it has no storage.
  function automatic int unsigned pc_idx(input int unsigned nregs);
    return nregs - 1;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-load flags and per-read-port busy indication.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS  = DefNregs,
  parameter int unsigned NREAD  = DefNread,
  parameter bit          BYPASS = DefBypass,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      set_pend_i,
  input  logic [AW-1:0]             pa_i,
  input  logic                      we0_i,
  input  logic [AW-1:0]             wa0_i,
  input  logic                      we1_i,
  input  logic [AW-1:0]             wa1_i,
  input  logic [NREAD-1:0][AW-1:0]  ra_i,
  output logic [NREGS-1:0]          pending_o,
  output logic [NREAD-1:0]          rbusy_o
);

  logic [NREGS-1:0] pending_q, pending_d;

  // Next pending state: a new load issue beats a same-cycle writeback clear.
  always_comb begin
    pending_d = pending_q;
    for (int unsigned k = 0; k < NREGS; k++) begin
      if (k == pc_idx(NREGS)) begin
        pending_d[k] = 1'b0;
      end else if (set_pend_i && (pa_i == AW'(k))) begin
        pending_d[k] = 1'b1;
      end else if ((we0_i && (wa0_i == AW'(k))) || (we1_i && (wa1_i == AW'(k)))) begin
        pending_d[k] = 1'b0;
      end
    end
  end

  // Pending flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_rbusy
    logic wr_hit;
    assign wr_hit     = (we0_i && (wa0_i == ra_i[i])) || (we1_i && (wa1_i == ra_i[i]));
    // With bypass the arriving write data satisfies the read, so it is not busy.
    assign rbusy_o[i] = pending_q[ra_i[i]] & ~(BYPASS & wr_hit);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port architectural register file with optional write bypass and load scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned NREGS  = DefNregs,
  parameter int unsigned NREAD  = DefNread,
  parameter bit          BYPASS = DefBypass,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREAD-1:0][AW-1:0]     ra,
  output logic [NREAD-1:0][WIDTH-1:0]  rd,
  input  logic [WIDTH-1:0]             pc,
  input  logic                         we0,
  input  logic [AW-1:0]                wa0,
  input  logic [WIDTH-1:0]             wd0,
  input  logic                         we1,
  input  logic [AW-1:0]                wa1,
  input  logic [WIDTH-1:0]             wd1,
  input  logic                         set_pend,
  input  logic [AW-1:0]                pa,
  output logic [NREGS-1:0]             pending,
  output logic [NREAD-1:0]             rbusy
);

  localparam logic [AW-1:0] PcIdx    = AW'(pc_idx(NREGS));
  localparam bit            Port1Win = (PortPrio == 1);

  // Ports re-ordered by priority; writes are gated off while reset is held.
  logic             hi_we, lo_we;
  logic [AW-1:0]    hi_wa, lo_wa;
  logic [WIDTH-1:0] hi_wd, lo_wd;

  assign hi_we = (Port1Win ? we1 : we0) & reset;
  assign hi_wa = Port1Win ? wa1 : wa0;
  assign hi_wd = Port1Win ? wd1 : wd0;
  assign lo_we = (Port1Win ? we0 : we1) & reset;
  assign lo_wa = Port1Win ? wa0 : wa1;
  assign lo_wd = Port1Win ? wd0 : wd1;

  logic [NREGS-2:0][WIDTH-1:0] mem_q, mem_d;
  logic [NREGS-1:0][WIDTH-1:0] rf_view;

  // Next storage contents; the PC index never matches a storage slot.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned k = 0; k < NREGS - 1; k++) begin
      if (hi_we && (hi_wa == AW'(k))) begin
        mem_d[k] = hi_wd;
      end else if (lo_we && (lo_wa == AW'(k))) begin
        mem_d[k] = lo_wd;
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rf_view = {pc, mem_q};

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [WIDTH-1:0] rd_val;
    // Read mux with optional same-cycle forwarding of write data.
    always_comb begin
      rd_val = rf_view[ra[i]];
      if (BYPASS && (ra[i] != PcIdx)) begin
        if (hi_we && (hi_wa == ra[i])) begin
          rd_val = hi_wd;
        end else if (lo_we && (lo_wa == ra[i])) begin
          rd_val = lo_wd;
        end
      end
    end
    assign rd[i] = rd_val;
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_scoreboard (
    .clk_i      (clk),
    .rst_ni     (reset),
    .set_pend_i (set_pend),
    .pa_i       (pa),
    .we0_i      (we0 & reset),
    .wa0_i      (wa0),
    .we1_i      (we1 & reset),
    .wa1_i      (wa1),
    .ra_i       (ra),
    .pending_o  (pending),
    .rbusy_o    (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp; a BYPASS=0 copy shares all inputs.
module tb_regfile_mp;

  logic             clk;
  logic             reset;
  logic [2:0][3:0]  ra;
  logic [2:0][31:0] rd, rd_nb;
  logic [31:0]      pc;
  logic             we0, we1, set_pend;
  logic [3:0]       wa0, wa1, pa;
  logic [31:0]      wd0, wd1;
  logic [15:0]      pending, pending_nb;
  logic [2:0]       rbusy, rbusy_nb;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp #(.WIDTH(32), .NREGS(16), .NREAD(3), .BYPASS(1'b1)) u_dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .pc(pc),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .set_pend(set_pend), .pa(pa), .pending(pending), .rbusy(rbusy)
  );

  regfile_mp #(.WIDTH(32), .NREGS(16), .NREAD(3), .BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_nb), .pc(pc),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .set_pend(set_pend), .pa(pa), .pending(pending_nb), .rbusy(rbusy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0; set_pend = 1'b0;
    wa0 = '0; wa1 = '0; pa = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic test_reset();
    #1;
    ra = {4'd15, 4'd7, 4'd0};
    #1;
    n_tests++; if (rd[0] !== 32'h0) begin n_fail++; $display("FAIL rst_rd0: got %h want %h", rd[0], 32'h0); end
    n_tests++; if (rd[1] !== 32'h0) begin n_fail++; $display("FAIL rst_rd1: got %h want %h", rd[1], 32'h0); end
    n_tests++; if (rd[2] !== 32'h108) begin n_fail++; $display("FAIL rst_pc: got %h want %h", rd[2], 32'h108); end
    n_tests++; if (pending !== 16'h0) begin n_fail++; $display("FAIL rst_pend: got %h want %h", pending, 16'h0); end
    // Writes and set_pend must be ignored while reset is low.
    we0 = 1'b1; wa0 = 4'd1; wd0 = 32'h77; set_pend = 1'b1; pa = 4'd1; ra[0] = 4'd1;
    #1;
    n_tests++; if (rd[0] !== 32'h0) begin n_fail++; $display("FAIL rst_nobyp: got %h want %h", rd[0], 32'h0); end
    @(posedge clk); #1;
    n_tests++; if (pending !== 16'h0) begin n_fail++; $display("FAIL rst_noset: got %h want %h", pending, 16'h0); end
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    n_tests++; if (rd[0] !== 32'h0) begin n_fail++; $display("FAIL rst_nowr: got %h want %h", rd[0], 32'h0); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hDEADBEEF; ra[0] = 4'd3;
    #1;
    n_tests++; if (rd[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_byp: got %h want %h", rd[0], 32'hDEADBEEF); end
    n_tests++; if (rd_nb[0] !== 32'h0) begin n_fail++; $display("FAIL wr_nobyp_old: got %h want %h", rd_nb[0], 32'h0); end
    @(posedge clk); #1;
    idle_inputs();
    #1;
    n_tests++; if (rd[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_stored: got %h want %h", rd[0], 32'hDEADBEEF); end
    n_tests++; if (rd_nb[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_nobyp_new: got %h want %h", rd_nb[0], 32'hDEADBEEF); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h11; we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h22; ra[0] = 4'd5;
    #1;
    n_tests++; if (rd[0] !== 32'h22) begin n_fail++; $display("FAIL coll_byp: got %h want %h", rd[0], 32'h22); end
    @(posedge clk); #1;
    idle_inputs();
    #1;
    n_tests++; if (rd[0] !== 32'h22) begin n_fail++; $display("FAIL coll_stored: got %h want %h", rd[0], 32'h22); end
    n_tests++; if (rd_nb[0] !== 32'h22) begin n_fail++; $display("FAIL coll_nb: got %h want %h", rd_nb[0], 32'h22); end
    @(negedge clk);
    pc = 32'h200; we0 = 1'b1; wa0 = 4'd15; wd0 = 32'h55; ra[2] = 4'd15;
    #1;
    n_tests++; if (rd[2] !== 32'h200) begin n_fail++; $display("FAIL pc_nobyp: got %h want %h", rd[2], 32'h200); end
    @(posedge clk); #1;
    idle_inputs();
    #1;
    n_tests++; if (rd[2] !== 32'h200) begin n_fail++; $display("FAIL pc_wr: got %h want %h", rd[2], 32'h200); end
    n_tests++; if (rd[0] !== 32'h22) begin n_fail++; $display("FAIL pc_r5: got %h want %h", rd[0], 32'h22); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    set_pend = 1'b1; pa = 4'd7; ra[1] = 4'd7;
    #1;
    n_tests++; if (pending[7] !== 1'b0) begin n_fail++; $display("FAIL sb_early: got %b want %b", pending[7], 1'b0); end
    @(posedge clk); #1;
    idle_inputs();
    #1;
    n_tests++; if (pending !== 16'h0080) begin n_fail++; $display("FAIL sb_set: got %h want %h", pending, 16'h0080); end
    n_tests++; if (rbusy !== 3'b010) begin n_fail++; $display("FAIL sb_busy: got %b want %b", rbusy, 3'b010); end
    @(negedge clk);
    we1 = 1'b1; wa1 = 4'd7; wd1 = 32'hCAFE;
    #1;
    n_tests++; if (rbusy[1] !== 1'b0) begin n_fail++; $display("FAIL sb_mask: got %b want %b", rbusy[1], 1'b0); end
    n_tests++; if (rbusy_nb[1] !== 1'b1) begin n_fail++; $display("FAIL sb_nomask: got %b want %b", rbusy_nb[1], 1'b1); end
    n_tests++; if (rd[1] !== 32'hCAFE) begin n_fail++; $display("FAIL sb_byp: got %h want %h", rd[1], 32'hCAFE); end
    @(posedge clk); #1;
    idle_inputs();
    #1;
    n_tests++; if (pending !== 16'h0) begin n_fail++; $display("FAIL sb_clr: got %h want %h", pending, 16'h0); end
    n_tests++; if (rd_nb[1] !== 32'hCAFE) begin n_fail++; $display("FAIL sb_data: got %h want %h", rd_nb[1], 32'hCAFE); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    set_pend = 1'b1; pa = 4'd4; we0 = 1'b1; wa0 = 4'd4; wd0 = 32'h1234; ra[0] = 4'd4;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    n_tests++; if (pending !== 16'h0010) begin n_fail++; $display("FAIL prio_pend: got %h want %h", pending, 16'h0010); end
    n_tests++; if (rd[0] !== 32'h1234) begin n_fail++; $display("FAIL prio_data: got %h want %h", rd[0], 32'h1234); end
    n_tests++; if (rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL prio_busy: got %b want %b", rbusy[0], 1'b1); end
    @(negedge clk);
    set_pend = 1'b1; pa = 4'd15;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    n_tests++; if (pending !== 16'h0010) begin n_fail++; $display("FAIL prio_pcpend: got %h want %h", pending, 16'h0010); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd2; wd0 = 32'h99; ra[0] = 4'd2; ra[1] = 4'd3;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    set_pend = 1'b1; pa = 4'd2;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    n_tests++; if (pending !== 16'h0014) begin n_fail++; $display("FAIL ar_pre_pend: got %h want %h", pending, 16'h0014); end
    n_tests++; if (rd[0] !== 32'h99) begin n_fail++; $display("FAIL ar_pre_rd: got %h want %h", rd[0], 32'h99); end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_tests++; if (pending !== 16'h0) begin n_fail++; $display("FAIL ar_pend: got %h want %h", pending, 16'h0); end
    n_tests++; if (rd[0] !== 32'h0) begin n_fail++; $display("FAIL ar_r2: got %h want %h", rd[0], 32'h0); end
    n_tests++; if (rd[1] !== 32'h0) begin n_fail++; $display("FAIL ar_r3: got %h want %h", rd[1], 32'h0); end
    n_tests++; if (rd[2] !== 32'h200) begin n_fail++; $display("FAIL ar_pc: got %h want %h", rd[2], 32'h200); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    pc = 32'h108;
    ra = '0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_collision();
    test_scoreboard();
    test_priority();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the multicycle ARM datapath: NREAD combinational read ports, two clocked write ports (ALU result and load/base writeback), an optional write-to-read bypass, and a per-register pending-load scoreboard. It replaces the fixed 2-read/1-write 15-entry file. It is the single architectural register store between decode and writeback.

## Interface
- WIDTH, 32, register data width
- NREGS, 16, number of architectural indices, including the PC index
- NREAD, 3, number of read ports (Rn, Rm, Rs)
- BYPASS, 1, 1 = a read sees same-cycle write data; 0 = a read sees stored data only
- AW, $clog2(NREGS), address width (derived; not overridden)
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- ra  input  [NREAD-1:0][AW-1:0]  read addresses
- rd  output  [NREAD-1:0][WIDTH-1:0]  read data
- pc  input  WIDTH  value returned for the PC index (PC+8, supplied by the datapath)
- we0, wa0, wd0  input  1 / AW / WIDTH  write port 0 (ALU result)
- we1, wa1, wd1  input  1 / AW / WIDTH  write port 1 (load data / base writeback)
- set_pend, pa  input  1 / AW  mark register pa pending (multicycle load issued)
- pending  output  NREGS  per-register pending flags
- rbusy  output  NREAD  read port i addresses a register that is still pending

## Operation
- Storage: NREGS-1 entries, indices 0..NREGS-2. Index NREGS-1 (PC_IDX) has no storage.
- Read: rd[i] = pc if ra[i]==PC_IDX, else the entry's value.
- BYPASS=1: if a write enable is high and its address matches ra[i] (and is not PC_IDX), rd[i] returns that port's wd. If both ports match, wd1 is returned.
- Write: we0/we1 update at the clock edge. Writes to PC_IDX are silently ignored.
- Both ports writing the same address: port 1 wins.
- Scoreboard set: set_pend marks pending[pa] at the edge.
- Scoreboard clear: any write to a register clears its pending bit.
- Same-cycle set and clear on one register: set wins.
- pending[PC_IDX] is always 0; set_pend with pa==PC_IDX is ignored.
- rbusy[i] = pending[ra[i]]. When BYPASS=1 it is additionally masked to 0 if a same-cycle write to ra[i] is present.

## Timing
- Reads, rd and rbusy: combinational, zero latency.
- Writes and pending updates: one edge; visible on the next cycle (same cycle via bypass when BYPASS=1).
- reset low: immediately and asynchronously clears all entries to 0 and all pending bits to 0.
  - rd reflects 0 (or pc for PC_IDX) while reset is held.
  - Writes and set_pend are ignored while reset is low.
- Reset deasserting mid-load: the pending state is lost. The load FSM is reset by the same signal, so this is consistent.
- No handshake: the controller must stall on any rbusy bit it needs.

## Structure
- Package regfile_pkg: PC_IDX function of NREGS, the default parameter values, and the port-select priority constant (port 1 wins).
- Sub-module rf_scoreboard: holds pending[NREGS-1:0] and computes set/clear priority and rbusy.
- Storage, bypass and read muxing stay in regfile_mp.
- Generate loops over NREAD. No vendor RAM inference is required: the file is flops.

## Test plan
- Reset-and-PC check: reset low with pc=0x00000108.
  - Every rd = 0, except ra=15, which returns 0x00000108.
  - pending = 0.
- Write then read: we0, wa0=3, wd0=0xDEADBEEF at edge N.
  - Same cycle with BYPASS=1: rd[0] (ra=3) = 0xDEADBEEF.
  - With BYPASS=0: old value until edge N, then 0xDEADBEEF.
- Write collision and PC protection: we0 and we1 both to r5, wd0=0x11, wd1=0x22.
  - r5 reads 0x22 afterwards.
  - A write of 0x55 to r15 leaves a read of r15 = pc.
- Scoreboard set and clear: set_pend with pa=7; ra[1]=7.
  - rbusy[1]=1 and pending[7]=1 on the next cycle.
  - we1 to r7 with 0xCAFE: rbusy[1] clears the same cycle (BYPASS=1) and pending[7]=0 after the edge.
- Scoreboard priority: set_pend with pa=4 and we0 with wa0=4 in the same cycle.
  - pending[4]=1 after the edge.
  - r4 holds the new wd0.
- Async reset mid-operation: pending[2]=1 and r2=0x99, then reset pulsed low between edges.
  - pending=0 and r2 reads 0 immediately, without a clock edge.
